// File: rtl/oven_pkg.sv
// Shared types and constants for the oven cook-cycle controller:
// FSM state encoding, BCD digit widths, and the MM:SS saturation limit.
package oven_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COOK   = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int ONES_W = 4;
  localparam int TENS_W = 3;

  localparam logic [ONES_W-1:0] BCD_MAX_ONES = 4'd9;
  localparam logic [TENS_W-1:0] BCD_MAX_TENS = 3'd5;

  typedef struct packed {
    logic [TENS_W-1:0] min_tens;
    logic [ONES_W-1:0] min_ones;
    logic [TENS_W-1:0] sec_tens;
    logic [ONES_W-1:0] sec_ones;
  } mmss_t;

  localparam mmss_t MMSS_SAT = '{min_tens: BCD_MAX_TENS, min_ones: BCD_MAX_ONES,
                                 sec_tens: BCD_MAX_TENS, sec_ones: BCD_MAX_ONES};
  localparam mmss_t MMSS_ONE = '{min_tens: '0, min_ones: '0,
                                 sec_tens: '0, sec_ones: ONES_W'(1)};

endpackage

// File: rtl/oven_mmss_bcd_counter.sv
// MM:SS BCD cook-time register with clear, borrow-chained decrement and
// saturating add-30; decrement is applied before the add in the same cycle.
module mmss_bcd_counter
  import oven_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  clr,
  input  logic  dec,
  input  logic  add30,
  output mmss_t count,
  output logic  zero,
  output logic  at_one
);

  localparam int SUM_W = TENS_W + 1;

  mmss_t count_q, count_d, dec_val;
  logic [SUM_W-1:0] sec_tens_sum;

  always_comb begin
    dec_val = count_q;
    if (dec && !zero) begin
      if (count_q.sec_ones != '0) begin
        dec_val.sec_ones = count_q.sec_ones - ONES_W'(1);
      end else begin
        dec_val.sec_ones = BCD_MAX_ONES;
        if (count_q.sec_tens != '0) begin
          dec_val.sec_tens = count_q.sec_tens - TENS_W'(1);
        end else begin
          dec_val.sec_tens = BCD_MAX_TENS;
          if (count_q.min_ones != '0) begin
            dec_val.min_ones = count_q.min_ones - ONES_W'(1);
          end else begin
            dec_val.min_ones = BCD_MAX_ONES;
            dec_val.min_tens = count_q.min_tens - TENS_W'(1);
          end
        end
      end
    end

    // Adding 30 s only touches sec_tens; a carry ripples into the minutes.
    count_d      = dec_val;
    sec_tens_sum = {1'b0, dec_val.sec_tens} + SUM_W'(3);
    if (add30) begin
      if (sec_tens_sum > {1'b0, BCD_MAX_TENS}) begin
        count_d.sec_tens = TENS_W'(sec_tens_sum - SUM_W'(6));
        if (dec_val.min_ones == BCD_MAX_ONES) begin
          count_d.min_ones = '0;
          if (dec_val.min_tens == BCD_MAX_TENS) begin
            count_d = MMSS_SAT;
          end else begin
            count_d.min_tens = dec_val.min_tens + TENS_W'(1);
          end
        end else begin
          count_d.min_ones = dec_val.min_ones + ONES_W'(1);
        end
      end else begin
        count_d.sec_tens = sec_tens_sum[TENS_W-1:0];
      end
    end

    if (clr) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count  = count_q;
  assign zero   = (count_q == '0);
  assign at_one = (count_q == MMSS_ONE);

endmodule

// File: rtl/oven_cook_ctrl.sv
// Oven cook-cycle controller: button edge detect, cook FSM, 1 s prescaler and
// DONE beeper. Define OVEN_BEEP_PULSE_EN for a chirping beep instead of steady.
module oven_cook_ctrl
  import oven_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 50_000_000,
  parameter int unsigned BEEP_CYCLES = 100_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_start,
  input  logic              btn_stop,
  input  logic              btn_add30,
  input  logic              door_open,
  output logic [ONES_W-1:0] sec_ones,
  output logic [TENS_W-1:0] sec_tens,
  output logic [ONES_W-1:0] min_ones,
  output logic [TENS_W-1:0] min_tens,
  output logic              heater_on,
  output logic              beep,
  output logic [1:0]        state
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BEEP_W = (BEEP_CYCLES > 1) ? $clog2(BEEP_CYCLES) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [BEEP_W-1:0] BEEP_LAST = BEEP_W'(BEEP_CYCLES - 1);

  state_t state_q, state_d;
  logic start_prev_q, start_prev_d;
  logic stop_prev_q, stop_prev_d;
  logic add_prev_q, add_prev_d;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [BEEP_W-1:0] beep_cnt_q, beep_cnt_d;
  logic heater_q, heater_d;
  logic beep_q, beep_d;
  logic start_e, stop_e, add_e, tick;
  logic clr, dec, add;
  mmss_t count;
  logic zero, at_one;

  mmss_bcd_counter u_counter (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .dec   (dec),
    .add30 (add),
    .count (count),
    .zero  (zero),
    .at_one(at_one)
  );

  always_comb begin
    start_prev_d = btn_start;
    stop_prev_d  = btn_stop;
    add_prev_d   = btn_add30;
    start_e      = btn_start & ~start_prev_q;
    stop_e       = btn_stop & ~stop_prev_q;
    add_e        = btn_add30 & ~add_prev_q;
  end

  // Same-cycle priority is stop, then door, then start; add30 rides along.
  always_comb begin
    state_d    = state_q;
    clr        = 1'b0;
    dec        = 1'b0;
    add        = 1'b0;
    tick       = 1'b0;
    tick_cnt_d = '0;
    beep_cnt_d = '0;
    case (state_q)
      IDLE: begin
        if (stop_e) begin
          clr = 1'b1;
        end else begin
          add = add_e;
          if (start_e && !door_open) begin
            state_d = COOK;
            if (zero) add = 1'b1;
          end
        end
      end
      COOK: begin
        add = add_e;
        if (tick_cnt_q == TICK_LAST) begin
          tick = 1'b1;
        end else begin
          tick_cnt_d = tick_cnt_q + TICK_W'(1);
        end
        if (stop_e || door_open) begin
          state_d    = PAUSED;
          tick_cnt_d = '0;
        end else if (tick) begin
          dec = 1'b1;
          if (at_one && !add_e) state_d = DONE;
        end
      end
      PAUSED: begin
        if (stop_e) begin
          state_d = IDLE;
          clr     = 1'b1;
        end else begin
          add = add_e;
          if (start_e && !door_open) state_d = COOK;
        end
      end
      DONE: begin
        if (start_e || stop_e || add_e || door_open) begin
          state_d = IDLE;
        end else if (beep_cnt_q == BEEP_LAST) begin
          state_d = IDLE;
        end else begin
          beep_cnt_d = beep_cnt_q + BEEP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    heater_d = (state_d == COOK);
  end

`ifdef OVEN_BEEP_PULSE_EN
  localparam int unsigned CHIRP_DIV = (TICK_DIV / 4 > 0) ? TICK_DIV / 4 : 1;
  localparam int CHIRP_W = (CHIRP_DIV > 1) ? $clog2(CHIRP_DIV) : 1;
  localparam logic [CHIRP_W-1:0] CHIRP_LAST = CHIRP_W'(CHIRP_DIV - 1);

  logic [CHIRP_W-1:0] chirp_cnt_q, chirp_cnt_d;

  always_comb begin
    beep_d      = 1'b0;
    chirp_cnt_d = '0;
    if (state_d == DONE) begin
      if (state_q != DONE) begin
        beep_d = 1'b1;
      end else if (chirp_cnt_q == CHIRP_LAST) begin
        beep_d = ~beep_q;
      end else begin
        beep_d      = beep_q;
        chirp_cnt_d = chirp_cnt_q + CHIRP_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chirp_cnt_q <= '0;
    end else begin
      chirp_cnt_q <= chirp_cnt_d;
    end
  end
`else
  always_comb begin
    beep_d = (state_d == DONE);
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      start_prev_q <= 1'b0;
      stop_prev_q  <= 1'b0;
      add_prev_q   <= 1'b0;
      tick_cnt_q   <= '0;
      beep_cnt_q   <= '0;
      heater_q     <= 1'b0;
      beep_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_prev_q <= start_prev_d;
      stop_prev_q  <= stop_prev_d;
      add_prev_q   <= add_prev_d;
      tick_cnt_q   <= tick_cnt_d;
      beep_cnt_q   <= beep_cnt_d;
      heater_q     <= heater_d;
      beep_q       <= beep_d;
    end
  end

  assign sec_ones  = count.sec_ones;
  assign sec_tens  = count.sec_tens;
  assign min_ones  = count.min_ones;
  assign min_tens  = count.min_tens;
  assign heater_on = heater_q;
  assign beep      = beep_q;
  assign state     = state_q;

endmodule

// File: tb/tb_oven_cook_ctrl.sv
// Directed self-checking bench for oven_cook_ctrl with TICK_DIV=4, BEEP_CYCLES=8.
// Expected times are written as decimal MMSS (e.g. 130 means 01:30).
module tb_oven_cook_ctrl;

  localparam int unsigned TICK_DIV    = 4;
  localparam int unsigned BEEP_CYCLES = 8;

  logic clk, rst, btn_start, btn_stop, btn_add30, door_open;
  logic [3:0] sec_ones, min_ones;
  logic [2:0] sec_tens, min_tens;
  logic heater_on, beep;
  logic [1:0] state;

  int checkCount;
  int errorCount;

  oven_cook_ctrl #(
    .TICK_DIV   (TICK_DIV),
    .BEEP_CYCLES(BEEP_CYCLES)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_start(btn_start),
    .btn_stop (btn_stop),
    .btn_add30(btn_add30),
    .door_open(door_open),
    .sec_ones (sec_ones),
    .sec_tens (sec_tens),
    .min_ones (min_ones),
    .min_tens (min_tens),
    .heater_on(heater_on),
    .beep     (beep),
    .state    (state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int timeValue();
    return int'(min_tens) * 1000 + int'(min_ones) * 100 + int'(sec_tens) * 10 + int'(sec_ones);
  endfunction

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic p, input logic a);
    btn_start = s;
    btn_stop  = p;
    btn_add30 = a;
    cycles(1);
    btn_start = 1'b0;
    btn_stop  = 1'b0;
    btn_add30 = 1'b0;
  endtask

  initial begin
    int expBeep;
    checkCount = 0;
    errorCount = 0;
    rst       = 1'b1;
    btn_start = 1'b0;
    btn_stop  = 1'b0;
    btn_add30 = 1'b0;
    door_open = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    checkOutput("reset_state", int'(state), 0);
    checkOutput("reset_heater", int'(heater_on), 0);
    checkOutput("reset_beep", int'(beep), 0);
    checkOutput("reset_time", timeValue(), 0);

    // quick-start from 00:00 then full countdown into DONE
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("qs_time", timeValue(), 30);
    checkOutput("qs_state", int'(state), 1);
    checkOutput("qs_heater", int'(heater_on), 1);
    cycles(3);
    checkOutput("qs_before_tick", timeValue(), 30);
    cycles(1);
    checkOutput("qs_first_tick", timeValue(), 29);
    cycles(115);
    checkOutput("qs_at_one", timeValue(), 1);
    checkOutput("qs_at_one_state", int'(state), 1);
    cycles(1);
    checkOutput("done_time", timeValue(), 0);
    checkOutput("done_state", int'(state), 3);
    checkOutput("done_heater", int'(heater_on), 0);
    for (int k = 0; k < 8; k++) begin
`ifdef OVEN_BEEP_PULSE_EN
      expBeep = (k % 2 == 0) ? 1 : 0;
`else
      expBeep = 1;
`endif
      checkOutput($sformatf("beep_k%0d", k), int'(beep), expBeep);
      checkOutput($sformatf("done_hold_k%0d", k), int'(state), 3);
      cycles(1);
    end
    checkOutput("done_timeout_state", int'(state), 0);
    checkOutput("done_timeout_beep", int'(beep), 0);

    // add30 x3 in IDLE, then minute-to-second borrow
    applyStimulus(1'b0, 1'b0, 1'b1);
    cycles(1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    cycles(1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("add3_time", timeValue(), 130);
    checkOutput("add3_state", int'(state), 0);
    cycles(1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("add3_start_time", timeValue(), 130);
    checkOutput("add3_start_state", int'(state), 1);
    cycles(123);
    checkOutput("borrow_pre", timeValue(), 100);
    cycles(1);
    checkOutput("borrow_post", timeValue(), 59);
    cycles(56);
    checkOutput("cook_45", timeValue(), 45);

    // door opens mid-cook, start ignored while open
    door_open = 1'b1;
    cycles(1);
    checkOutput("door_state", int'(state), 2);
    checkOutput("door_heater", int'(heater_on), 0);
    checkOutput("door_time", timeValue(), 45);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("door_start_ignored", int'(state), 2);
    cycles(5);
    checkOutput("paused_hold_time", timeValue(), 45);
    checkOutput("paused_hold_state", int'(state), 2);
    door_open = 1'b0;
    cycles(1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("resume_state", int'(state), 1);
    checkOutput("resume_heater", int'(heater_on), 1);
    cycles(3);
    checkOutput("resume_before_tick", timeValue(), 45);
    cycles(1);
    checkOutput("resume_tick", timeValue(), 44);
    cycles(116);
    checkOutput("cook_15", timeValue(), 15);

    // pause at 00:15, add up to 59:45, then saturate
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("stop_pause_state", int'(state), 2);
    checkOutput("stop_pause_time", timeValue(), 15);
    for (int i = 0; i < 119; i++) begin
      cycles(1);
      applyStimulus(1'b0, 1'b0, 1'b1);
    end
    checkOutput("time_5945", timeValue(), 5945);
    cycles(1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("sat_5959", timeValue(), 5959);
    cycles(1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("sat_hold", timeValue(), 5959);
    cycles(1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("sat_cook_state", int'(state), 1);
    cycles(1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("stop_start_state", int'(state), 2);
    checkOutput("stop_start_time", timeValue(), 5959);
    checkOutput("stop_start_heater", int'(heater_on), 0);
    cycles(1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("cancel_state", int'(state), 0);
    checkOutput("cancel_time", timeValue(), 0);

    // add30+start at 00:00 gives 00:30 once; abort DONE with add30
    cycles(1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("combo_time", timeValue(), 30);
    checkOutput("combo_state", int'(state), 1);
    cycles(119);
    checkOutput("combo_at_one", timeValue(), 1);
    cycles(1);
    checkOutput("combo_done_state", int'(state), 3);
    checkOutput("combo_done_beep", int'(beep), 1);
    cycles(3);
    checkOutput("abort_pre_state", int'(state), 3);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("abort_state", int'(state), 0);
    checkOutput("abort_beep", int'(beep), 0);
    checkOutput("abort_time", timeValue(), 0);

    // asynchronous reset between clock edges while cooking
    cycles(1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("arst_cook_state", int'(state), 1);
    cycles(5);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("arst_heater", int'(heater_on), 0);
    checkOutput("arst_state", int'(state), 0);
    checkOutput("arst_time", timeValue(), 0);
    #1;
    rst = 1'b0;
    cycles(2);
    checkOutput("arst_after_state", int'(state), 0);
    checkOutput("arst_after_heater", int'(heater_on), 0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/oven_cook_ctrl.md
# oven_cook_ctrl

Cook-cycle controller for the oven front panel: accepts start/stop/add-30 s buttons and the door switch, owns the MM:SS cook time, counts it down once per second, and drives the heater and done beeper. It sits between the panel inputs and the seven-segment display decoders. It emits raw BCD digits; segment encoding stays in the display path.

## Interface
- `TICK_DIV`, default 50_000_000: clock cycles per one-second countdown tick.
- `BEEP_CYCLES`, default 100_000_000: beeper duration in DONE, in clock cycles.
- `clk` in 1: system clock; all logic on rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `btn_start` in 1: start/resume; level, synchronous to `clk`, debounced upstream.
- `btn_stop` in 1: pause/cancel; level, debounced.
- `btn_add30` in 1: add 30 s; level, debounced.
- `door_open` in 1: door switch level; 1 = open.
- `sec_ones` out 4: BCD 0–9.
- `sec_tens` out 3: BCD 0–5.
- `min_ones` out 4: BCD 0–9.
- `min_tens` out 3: BCD 0–5.
- `heater_on` out 1: magnetron/heater enable.
- `beep` out 1: beeper drive.
- `state` out 2: current state encoding (IDLE=0, COOK=1, PAUSED=2, DONE=3).

## Operation
- Buttons are rising-edge detected internally using a registered copy of each input. Only the edge cycle acts; holding a button has no further effect.
- **IDLE**:
  - add30 adds 30 s, saturating at 59:59.
  - start with door closed → COOK. If the time is 00:00, it first loads 00:30 (quick-start).
  - stop clears the time to 00:00.
- **COOK**:
  - `heater_on`=1.
  - Each tick decrements MM:SS with BCD borrow: sec_ones 0→9 borrows from sec_tens, sec_tens 0→5 borrows from min_ones, and so on.
  - A decrement reaching 00:00 → DONE.
  - add30 adds 30 s, saturating.
  - stop or door_open=1 → PAUSED, time held.
- **PAUSED**:
  - start with door closed → COOK.
  - stop → IDLE with time cleared to 00:00.
  - add30 adds 30 s.
- **DONE**:
  - `beep` drives per Configuration.
  - After BEEP_CYCLES cycles → IDLE.
  - Any button edge or door_open=1 → IDLE immediately.
  - Time stays 00:00.
- **Same-cycle priority**:
  - stop > door_open > start.
  - add30 is applied in the same cycle as start. An add30+start edge from IDLE at 00:00 yields 00:30, with no quick-start double-add.
- Start while door_open=1 is ignored in every state.

## Timing
- Reset values: time 00:00, state IDLE, `heater_on`=0, `beep`=0, tick prescaler 0, edge registers 0.
- All outputs are registered, one cycle after the causing input edge.
- The tick prescaler runs only in COOK. It clears to 0 on every entry to COOK, so the first decrement happens TICK_DIV cycles after `heater_on` rises.
- A tick and an add30 in the same cycle: the decrement is applied first, then the add, then saturation.
- `heater_on` falls in the same cycle the state leaves COOK.
- Reset asserted mid-cook forces IDLE/00:00 asynchronously; the heater drops without waiting for a clock.

## Configuration
- `OVEN_BEEP_PULSE_EN`:
  - Defined: in DONE, `beep` toggles every TICK_DIV/4 cycles (intermittent chirp) for BEEP_CYCLES.
  - Undefined: `beep` is held steady at 1 for BEEP_CYCLES.
  - In both cases `beep`=0 outside DONE.

## Structure
- Package `oven_pkg` holds:
  - the state enum and its 2-bit encoding;
  - the digit widths;
  - the BCD max constants (9, 5);
  - the 59:59 saturation constant.
- Sub-module `mmss_bcd_counter` holds the four BCD digits and provides:
  - synchronous clear, decrement, and add-30 with saturation;
  - a `zero` flag;
  - an `at_one` flag (00:01) used for the DONE transition.
- The controller FSM, edge detect, prescaler and beep timer stay in `oven_cook_ctrl`.

## Test plan
Benches use TICK_DIV=4 and BEEP_CYCLES=8.
- Reset → all outputs 0, state=0. Then start with door closed → 00:30, state=COOK, `heater_on`=1. After 30×4 cycles → 00:00, state=DONE, then IDLE 8 cycles later.
- add30 ×3 in IDLE → 01:30. Start, run 31 ticks → 00:59, verifying the min→sec borrow.
- COOK at 00:45, door_open=1 → PAUSED, `heater_on`=0, time holds. Start while door open → no change. Close door, start → COOK, next decrement exactly 4 cycles later.
- Time 59:45, add30 → 59:59 (saturated). Stop+start same cycle in COOK → PAUSED. Stop again → IDLE 00:00.
- In DONE, press add30 at cycle 3 of beep → IDLE immediately, `beep`=0, time 00:00. Check the `beep` waveform with `OVEN_BEEP_PULSE_EN` defined and undefined.
- Assert `rst` asynchronously mid-COOK between clock edges → `heater_on`=0 before the next edge, time 00:00.
